pim_result_aggregator: RTL and testbench

- Receiving end of the PIM result interface.
- Collects 8x8 partial-product tiles from NUM_PIM PIM units and accumulates them into an N x N output matrix, where N = BLOCKS*PIM_MATRIX_SIZE.
- A tile is complete after BLOCKS contributions, one per k-block.
- When all tiles are complete, the block streams the matrix out row by row over a valid/ready interface, then clears itself for the next job.

---
 rtl/pim_result_aggregator_pkg.sv | 24 ++
 rtl/pim_result_aggregator_rr_arbiter.sv | 54 +++++
 rtl/pim_result_aggregator.sv | 205 ++++++++++++++++++++
 tb/tb_pim_result_aggregator.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pim_result_aggregator_pkg.sv
// Shared types and helpers for the PIM result aggregator.
package pim_result_aggregator_pkg;

  localparam int ELEM_WIDTH_DEF = 32;
  localparam int TAG_W          = 8;

  typedef logic [ELEM_WIDTH_DEF-1:0] elem_t;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } agg_state_t;

  typedef struct packed {
    logic [TAG_W-1:0] row;
    logic [TAG_W-1:0] col;
  } pim_tag_t;

  // Index width for a range of n entries; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pim_result_aggregator_rr_arbiter.sv
// Round-robin arbiter: one grant per cycle, search starts at the pointer.
module rr_arbiter
  import pim_result_aggregator_pkg::*;
#(
  parameter  int NUM_PIM = 4,
  localparam int IW      = idx_w(NUM_PIM)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_PIM-1:0] req,
  input  logic               advance,
  output logic [NUM_PIM-1:0] gnt,
  output logic [IW-1:0]      gnt_idx
);

  logic [IW-1:0] ptr_q, ptr_d;

  // Pick the first requester at or after the pointer, wrapping around.
  always_comb begin
    int cand;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = 0;
    for (int k = 0; k < NUM_PIM; k++) begin
      cand = (int'(ptr_q) + k) % NUM_PIM;
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = IW'(cand);
      end
    end
  end

  // The pointer moves to the slot after the one just granted.
  always_comb begin
    if (gnt_idx == IW'(NUM_PIM - 1)) begin
      ptr_d = '0;
    end else begin
      ptr_d = gnt_idx + IW'(1);
    end
  end

  // Pointer register, updated only when a grant is actually consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (advance && (|req)) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/pim_result_aggregator.sv
// Collects S x S partial-product tiles from several PIM units, accumulates
// them into an N x N matrix and streams the result out row by row.
module pim_result_aggregator
  import pim_result_aggregator_pkg::*;
#(
  parameter  int ELEM_WIDTH      = 32,
  parameter  int PIM_MATRIX_SIZE = 8,
  parameter  int NUM_PIM         = 4,
  parameter  int BLOCKS          = 2,
  localparam int S               = PIM_MATRIX_SIZE,
  localparam int N               = BLOCKS * PIM_MATRIX_SIZE,
  localparam int TW              = idx_w(BLOCKS),
  localparam int RW              = idx_w(N)
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NUM_PIM-1:0]                            pim_valid,
  input  logic [NUM_PIM-1:0][S-1:0][S-1:0][ELEM_WIDTH-1:0] pim_result,
  input  logic [NUM_PIM-1:0][TW-1:0]                    pim_tile_row,
  input  logic [NUM_PIM-1:0][TW-1:0]                    pim_tile_col,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [N-1:0][ELEM_WIDTH-1:0]                  out_row,
  output logic [RW-1:0]                                 out_row_idx,
  output logic                                          out_last,
  output logic                                          overflow,
  output logic                                          tile_err
);

  localparam int IW = idx_w(NUM_PIM);
  localparam int CW = $clog2(BLOCKS + 1);

  // Pending slots: one per PIM, holding a full tile plus its destination.
  logic [S-1:0][S-1:0][ELEM_WIDTH-1:0] slot_data_q [NUM_PIM];
  pim_tag_t                            slot_tag_q  [NUM_PIM];
  logic [NUM_PIM-1:0]                  slot_full_q;

  // Accumulator matrix and per-tile contribution counts.
  logic [ELEM_WIDTH-1:0] acc_q [N][N];
  logic [CW-1:0]         cnt_q [BLOCKS][BLOCKS];

  agg_state_t    state_q, state_d;
  logic [RW-1:0] row_idx_q, row_idx_d;
  logic          overflow_q, tile_err_q;

  logic [NUM_PIM-1:0] gnt_s;
  logic [IW-1:0]      gnt_idx_s;
  logic [NUM_PIM-1:0] freed_s;
  logic               grant_s;
  logic [TW-1:0]      g_row_s, g_col_s;
  logic               tile_full_s;
  logic               all_done_s;
  logic               handshake_s;
  logic               drain_done_s;

  rr_arbiter #(
    .NUM_PIM(NUM_PIM)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (slot_full_q),
    .advance(grant_s),
    .gnt    (gnt_s),
    .gnt_idx(gnt_idx_s)
  );

  // Grants are only consumed while accumulating; draining leaves slots parked.
  always_comb begin
    grant_s     = (state_q == ACCUM) && (|slot_full_q);
    freed_s     = gnt_s & {NUM_PIM{grant_s}};
    g_row_s     = slot_tag_q[gnt_idx_s].row[TW-1:0];
    g_col_s     = slot_tag_q[gnt_idx_s].col[TW-1:0];
    tile_full_s = (cnt_q[g_row_s][g_col_s] == CW'(BLOCKS));
    handshake_s  = (state_q == DRAIN) && out_ready;
    drain_done_s = handshake_s && (row_idx_q == RW'(N - 1));
  end

  // The job is complete once every tile has received all its contributions.
  always_comb begin
    all_done_s = 1'b1;
    for (int a = 0; a < BLOCKS; a++) begin
      for (int b = 0; b < BLOCKS; b++) begin
        if (cnt_q[a][b] != CW'(BLOCKS)) begin
          all_done_s = 1'b0;
        end else begin
          all_done_s = all_done_s;
        end
      end
    end
  end

  // Next-state and row-index logic for the ACCUM/DRAIN sequencer.
  always_comb begin
    state_d   = state_q;
    row_idx_d = row_idx_q;
    case (state_q)
      ACCUM: begin
        if (all_done_s) begin
          state_d = DRAIN;
        end else begin
          state_d = ACCUM;
        end
      end
      DRAIN: begin
        if (drain_done_s) begin
          row_idx_d = '0;
          state_d   = ACCUM;
        end else if (handshake_s) begin
          row_idx_d = row_idx_q + RW'(1);
        end else begin
          row_idx_d = row_idx_q;
        end
      end
      default: begin
        state_d   = ACCUM;
        row_idx_d = '0;
      end
    endcase
  end

  // Sequencer state and output row pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACCUM;
      row_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      row_idx_q <= row_idx_d;
    end
  end

  // Slot capture: a slot freed by this edge's grant may take new data at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_full_q <= '0;
      for (int i = 0; i < NUM_PIM; i++) begin
        slot_data_q[i] <= '0;
        slot_tag_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PIM; i++) begin
        if (pim_valid[i] && (!slot_full_q[i] || freed_s[i])) begin
          slot_data_q[i]    <= pim_result[i];
          slot_tag_q[i].row <= TAG_W'(pim_tile_row[i]);
          slot_tag_q[i].col <= TAG_W'(pim_tile_col[i]);
          slot_full_q[i]    <= 1'b1;
        end else if (freed_s[i]) begin
          slot_full_q[i] <= 1'b0;
        end
      end
    end
  end

  // Sticky error flags; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
      tile_err_q <= 1'b0;
    end else begin
      overflow_q <= overflow_q | (|(pim_valid & slot_full_q & ~freed_s));
      tile_err_q <= tile_err_q | (grant_s & tile_full_s);
    end
  end

  // Accumulate the granted tile (mod 2^ELEM_WIDTH); clear after the last row drains.
  always_ff @(posedge clk) begin
    if (rst || drain_done_s) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          acc_q[r][c] <= '0;
        end
      end
      for (int a = 0; a < BLOCKS; a++) begin
        for (int b = 0; b < BLOCKS; b++) begin
          cnt_q[a][b] <= '0;
        end
      end
    end else if (grant_s && !tile_full_s) begin
      cnt_q[g_row_s][g_col_s] <= cnt_q[g_row_s][g_col_s] + CW'(1);
      for (int r = 0; r < S; r++) begin
        for (int c = 0; c < S; c++) begin
          acc_q[int'(g_row_s) * S + r][int'(g_col_s) * S + c] <=
            acc_q[int'(g_row_s) * S + r][int'(g_col_s) * S + c] + slot_data_q[gnt_idx_s][r][c];
        end
      end
    end
  end

  // Output view: all fields come straight from registers and hold while stalled.
  always_comb begin
    out_valid   = (state_q == DRAIN);
    out_row_idx = row_idx_q;
    out_last    = (state_q == DRAIN) && (row_idx_q == RW'(N - 1));
    overflow    = overflow_q;
    tile_err    = tile_err_q;
    for (int j = 0; j < N; j++) begin
      if (state_q == DRAIN) begin
        out_row[j] = acc_q[row_idx_q][j];
      end else begin
        out_row[j] = '0;
      end
    end
  end

endmodule

// File: tb/tb_pim_result_aggregator.sv
// Directed scoreboard bench for pim_result_aggregator (2 PIMs, 2x2 tiles of 8x8).
module tb_pim_result_aggregator;
  import pim_result_aggregator_pkg::*;

  localparam int EW = 32;
  localparam int S  = 8;
  localparam int NP = 2;
  localparam int B  = 2;
  localparam int N  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                            rst;
  logic [NP-1:0]                   pim_valid;
  logic [NP-1:0][S-1:0][S-1:0][EW-1:0] pim_result;
  logic [NP-1:0][0:0]              pim_tile_row;
  logic [NP-1:0][0:0]              pim_tile_col;
  logic                            out_valid;
  logic                            out_ready;
  logic [N-1:0][EW-1:0]            out_row;
  logic [3:0]                      out_row_idx;
  logic                            out_last;
  logic                            overflow;
  logic                            tile_err;

  int checks   = 0;
  int failures = 0;

  elem_t             m_acc [N][N];
  logic [N*EW-1:0]   exp_q [$];

  pim_result_aggregator #(
    .ELEM_WIDTH     (EW),
    .PIM_MATRIX_SIZE(S),
    .NUM_PIM        (NP),
    .BLOCKS         (B)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pim_valid   (pim_valid),
    .pim_result  (pim_result),
    .pim_tile_row(pim_tile_row),
    .pim_tile_col(pim_tile_col),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_row     (out_row),
    .out_row_idx (out_row_idx),
    .out_last    (out_last),
    .overflow    (overflow),
    .tile_err    (tile_err)
  );

  task automatic chk(input string tag, input logic [N*EW-1:0] obs, input logic [N*EW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic elem_t pat(input elem_t base, input elem_t step, input int r, input int c);
    return base + step * elem_t'(r * S + c);
  endfunction

  task automatic set_pim(input int p, input int tr, input int tc, input elem_t base, input elem_t step);
    pim_valid[p]    = 1'b1;
    pim_tile_row[p] = tr[0];
    pim_tile_col[p] = tc[0];
    for (int r = 0; r < S; r++)
      for (int c = 0; c < S; c++)
        pim_result[p][r][c] = pat(base, step, r, c);
  endtask

  task automatic pulse();
    tick();
    pim_valid = '0;
  endtask

  task automatic model_add(input int tr, input int tc, input elem_t base, input elem_t step);
    for (int r = 0; r < S; r++)
      for (int c = 0; c < S; c++)
        m_acc[tr*S + r][tc*S + c] = m_acc[tr*S + r][tc*S + c] + pat(base, step, r, c);
  endtask

  task automatic send1(input int p, input int tr, input int tc, input elem_t base, input elem_t step);
    set_pim(p, tr, tc, base, step);
    pulse();
    model_add(tr, tc, base, step);
  endtask

  task automatic model_clear();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        m_acc[r][c] = '0;
  endtask

  task automatic push_job();
    logic [N*EW-1:0] row;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++)
        row[c*EW +: EW] = m_acc[r][c];
      exp_q.push_back(row);
    end
    model_clear();
  endtask

  // Full job: every tile gets two contributions, alternating PIM0/PIM1.
  task automatic uniform_job(input elem_t v);
    for (int k = 0; k < 8; k++)
      send1(k % 2, (k / 4) % 2, (k / 2) % 2, v, 32'd0);
    push_job();
  endtask

  task automatic drain_job(input int stall_row, input int stall_len, input int abort_row);
    logic [N*EW-1:0] er;
    logic [N*EW-1:0] held;
    int n;
    n = 0;
    chk("no_early_valid", out_valid, 1'b0);
    while (!out_valid && n < 30) begin
      tick();
      n++;
    end
    chk("drain_start", out_valid, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      er = exp_q.pop_front();
      chk($sformatf("row%0d_valid", i), out_valid, 1'b1);
      chk($sformatf("row%0d_idx", i), out_row_idx, i);
      chk($sformatf("row%0d_last", i), out_last, (i == N - 1));
      chk($sformatf("row%0d_data", i), out_row, er);
      if (i == abort_row) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        chk("abort_valid", out_valid, 1'b0);
        chk("abort_idx", out_row_idx, 4'd0);
        chk("abort_last", out_last, 1'b0);
        chk("abort_overflow", overflow, 1'b0);
        chk("abort_tile_err", tile_err, 1'b0);
        chk("abort_row_zero", out_row, '0);
        exp_q.delete();
        return;
      end
      if (i == stall_row) begin
        out_ready = 1'b0;
        held = out_row;
        for (int k = 0; k < stall_len; k++) begin
          tick();
          chk($sformatf("stall%0d_idx", k), out_row_idx, i);
          chk($sformatf("stall%0d_row", k), out_row, held);
          chk($sformatf("stall%0d_valid", k), out_valid, 1'b1);
        end
        out_ready = 1'b1;
      end
      tick();
    end
    out_ready = 1'b0;
    chk("post_drain_valid", out_valid, 1'b0);
    chk("post_drain_idx", out_row_idx, 4'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired before the bench finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    out_ready    = 1'b0;
    pim_valid    = '0;
    pim_result   = '0;
    pim_tile_row = '0;
    pim_tile_col = '0;
    model_clear();
    repeat (3) tick();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_idx", out_row_idx, 4'd0);
    chk("rst_last", out_last, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_tile_err", tile_err, 1'b0);
    chk("rst_row", out_row, '0);
    rst = 1'b0;
    tick();

    // Full job of all-8 tiles: every element 16.
    uniform_job(32'd8);
    drain_job(-1, 0, -1);

    // Simultaneous pulses to tile (0,1), patterned tiles elsewhere, stall at row 3.
    set_pim(0, 0, 1, 32'd3, 32'd0);
    set_pim(1, 0, 1, 32'd5, 32'd0);
    pulse();
    model_add(0, 1, 32'd3, 32'd0);
    model_add(0, 1, 32'd5, 32'd0);
    tick();
    tick();
    send1(0, 0, 0, 32'd100, 32'd1);
    send1(0, 0, 0, 32'd100, 32'd1);
    send1(0, 1, 0, 32'd7, 32'd3);
    send1(1, 1, 0, 32'd1000, 32'd0);
    send1(0, 1, 1, 32'h0001_0000, 32'd2);
    send1(1, 1, 1, 32'd9, 32'd0);
    chk("c_overflow", overflow, 1'b0);
    chk("c_tile_err", tile_err, 1'b0);
    push_job();
    drain_job(3, 5, -1);

    // Overflow: PIM1 pulses twice back to back, PIM0's second pulse lands on a freed slot.
    set_pim(0, 0, 0, 32'd1, 32'd0);
    set_pim(1, 1, 1, 32'd2, 32'd0);
    pulse();
    model_add(0, 0, 32'd1, 32'd0);
    model_add(1, 1, 32'd2, 32'd0);
    set_pim(1, 1, 1, 32'd50, 32'd0);
    set_pim(0, 0, 0, 32'd4, 32'd0);
    pulse();
    model_add(0, 0, 32'd4, 32'd0);
    chk("d_overflow", overflow, 1'b1);
    tick();
    tick();
    send1(1, 1, 1, 32'd10, 32'd0);
    send1(0, 0, 1, 32'd20, 32'd1);
    send1(1, 0, 1, 32'd30, 32'd0);
    send1(0, 1, 0, 32'd40, 32'd0);
    send1(1, 1, 0, 32'd5, 32'd5);
    chk("d_tile_err", tile_err, 1'b0);
    push_job();
    drain_job(-1, 0, -1);
    chk("d_overflow_sticky", overflow, 1'b1);

    // Wrap-around sum then a third contribution to the completed tile.
    send1(0, 1, 0, 32'hFFFF_FFFF, 32'd0);
    send1(1, 1, 0, 32'd2, 32'd0);
    set_pim(0, 1, 0, 32'h55, 32'd0);
    pulse();
    tick();
    tick();
    chk("e_tile_err", tile_err, 1'b1);
    send1(0, 0, 0, 32'd6, 32'd0);
    send1(1, 0, 0, 32'd6, 32'd1);
    send1(0, 0, 1, 32'd11, 32'd0);
    send1(1, 0, 1, 32'd12, 32'd0);
    send1(0, 1, 1, 32'd13, 32'd0);
    send1(1, 1, 1, 32'd14, 32'd0);
    push_job();
    drain_job(-1, 0, -1);
    chk("e_tile_err_sticky", tile_err, 1'b1);

    // Reset in the middle of draining, then a clean all-1 job: every element 2.
    uniform_job(32'd9);
    drain_job(-1, 0, 5);
    tick();
    uniform_job(32'd1);
    drain_job(-1, 0, -1);
    chk("final_overflow", overflow, 1'b0);
    chk("final_tile_err", tile_err, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
